// File: rtl/s4ga_pkg.sv
// Shared s4ga-family definitions: configuration-image geometry and loader FSM states.
package s4ga_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CRST = 2'd2,
        S_RUN  = 2'd3
    } s4ga_state_e;

    // Segments needed to name any LUT source: 3 constants, I inputs, N LUT outputs.
    function automatic int idx_segs(input int n, input int i, input int si_w);
        return ($clog2(3 + i + n) + si_w - 1) / si_w;
    endfunction

    function automatic int mask_segs(input int k, input int si_w);
        return ((1 << k) + si_w - 1) / si_w;
    endfunction

    function automatic int line_len(input int k, input int idx, input int mask);
        return k * idx + mask;
    endfunction

    function automatic int image_depth(input int n, input int ll);
        return n * ll;
    endfunction

endpackage

// File: rtl/s4ga_seg_ram.sv
// DEPTH x W segment store: one write port, one registered read port with a clear.
module s4ga_seg_ram #(
    parameter int DEPTH = 21,
    parameter int W     = 4,
    parameter int A_W   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           we,
    input  logic [A_W-1:0] waddr,
    input  logic [W-1:0]   wdata,
    input  logic           re,
    input  logic           rclr,
    input  logic [A_W-1:0] raddr,
    output logic [W-1:0]   rdata
);

    logic [W-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rclr)    rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/s4ga_cfg_loader.sv
// Streams a configuration image into segment RAM, holds the core in reset, then replays it forever.
module s4ga_cfg_loader
    import s4ga_pkg::*;
#(
    parameter int N    = 283,
    parameter int K    = 5,
    parameter int I    = 2,
    parameter int SI_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_valid,
    input  logic [SI_W-1:0] load_data,
    input  logic            load_last,
    output logic            load_ready,
    input  logic            reload,
    output logic            core_rst,
    output logic [SI_W-1:0] si,
    output logic            frame_start,
    output logic            running,
    output logic            err_len
);

    localparam int IDX_SEGS  = idx_segs(N, I, SI_W);
    localparam int MASK_SEGS = mask_segs(K, SI_W);
    localparam int LL        = line_len(K, IDX_SEGS, MASK_SEGS);
    localparam int DEPTH     = image_depth(N, LL);
    localparam int A_W       = $clog2(DEPTH);
    localparam int CNT_W     = $clog2(N + 3);

    localparam logic [A_W-1:0]   LAST_ADDR = A_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N + 1);

    s4ga_state_e      state_q, state_d;
    logic [A_W-1:0]   wptr_q, wptr_d;
    logic [A_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_d;
    logic             accept;

    assign load_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept     = load_valid && load_ready;

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        err_d   = err_len;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    if (state_q == S_IDLE) err_d = 1'b0;
                    if (wptr_q == LAST_ADDR) begin
                        wptr_d = '0;
                        if (load_last) begin
                            state_d = S_CRST;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    end else if (load_last) begin
                        state_d = S_IDLE;
                        wptr_d  = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                        wptr_d  = wptr_q + 1'b1;
                    end
                end
            end
            S_CRST: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rptr_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (reload) begin
                    state_d = S_IDLE;
                    wptr_d  = '0;
                    rptr_d  = '0;
                end else begin
                    rptr_d = (rptr_q == LAST_ADDR) ? '0 : rptr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            err_len     <= 1'b0;
            core_rst    <= 1'b1;
            running     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
            err_len     <= err_d;
            core_rst    <= (state_d != S_RUN);
            running     <= (state_d == S_RUN);
            frame_start <= (state_d == S_RUN) && (rptr_d == '0);
        end
    end

    // rptr_d is the word shown next cycle; the last CRST cycle thus prefetches mem[0].
    s4ga_seg_ram #(
        .DEPTH (DEPTH),
        .W     (SI_W),
        .A_W   (A_W)
    ) u_ram (
        .clk   (clk),
        .we    (accept && rst),
        .waddr (wptr_q),
        .wdata (load_data),
        .re    (state_d == S_RUN),
        .rclr  (!rst || (state_d != S_RUN)),
        .raddr (rptr_d),
        .rdata (si)
    );

endmodule
